// File: rtl/accumulator_n_if.sv
// Handshake bundle for accumulator_n: operand stream in, packet result out.
interface accumulator_n_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic             out_carry;
  logic             out_overflow;
  logic [CNT_W-1:0] out_count;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_overflow, out_count
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_overflow, out_count
  );
endinterface

// File: rtl/accumulator_n.sv
// Streaming packet accumulator built around the adder_n combinational add core.
// Sums each packet into a register, tracks sticky carry/overflow and a saturating
// beat count, then holds the result on the output handshake until it is taken.

// Combinational N-bit adder with carry in/out.
module adder_n #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c_in,
  output logic [N-1:0] o_sum,
  output logic         o_c_out
);
  // One extra bit on top of the operands captures the carry out
  assign {o_c_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c_in};
endmodule

module accumulator_n #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  accumulator_n_if.slave     bus
);

  typedef enum logic {StAccum, StHold} state_e;

  state_e           r_state;
  logic [N-1:0]     r_acc;
  logic             r_carry;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic [N-1:0]     w_sum;
  logic             w_c_out;
  logic             w_ovf;

  adder_n #(.N(N)) u_adder (
    .i_a     (r_acc),
    .i_b     (bus.in_data),
    .i_c_in  (1'b0),
    .o_sum   (w_sum),
    .o_c_out (w_c_out)
  );

  // Signed overflow: operands agree in sign but the result does not
  assign w_ovf    = (r_acc[N-1] == bus.in_data[N-1]) && (w_sum[N-1] != r_acc[N-1]);
  assign w_accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready     = (r_state == StAccum) && !rst;
  assign bus.out_valid    = (r_state == StHold);
  assign bus.out_sum      = r_acc;
  assign bus.out_carry    = r_carry;
  assign bus.out_overflow = r_ovf;
  assign bus.out_count    = r_count;

  // Packet FSM: accumulate beats in StAccum, present and wait for the consumer in StHold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StAccum;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        StAccum: begin
          if (w_accept) begin
            r_acc   <= w_sum;
            r_carry <= r_carry | w_c_out;
            r_ovf   <= r_ovf | w_ovf;
            // Saturate rather than wrap so long packets never report a small count
            if (r_count != {CNT_W{1'b1}}) begin
              r_count <= r_count + CNT_W'(1);
            end
            if (bus.in_last) begin
              r_state <= StHold;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_state <= StAccum;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_n.sv
// Directed bench for accumulator_n: a per-cycle vector table plus a saturation sequence.
module tb_accumulator_n;

  logic clk;
  logic rst;

  accumulator_n_if #(.N(32), .CNT_W(8)) bus  ();
  accumulator_n_if #(.N(32), .CNT_W(2)) bus2 ();

  accumulator_n #(.N(32), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  accumulator_n #(.N(32), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] data;
    logic        last;
    logic        ordy;
    logic        exp_ir;
    logic        chk_ov;
    logic        exp_ov;
    logic        chk_data;
    logic [31:0] exp_sum;
    logic        exp_c;
    logic        exp_o;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic l,
                     input logic ordy, input logic ir, input logic cov, input logic ov,
                     input logic cd, input logic [31:0] s, input logic c, input logic o,
                     input logic [7:0] n);
    vec_t v;
    v.rst = r; v.iv = iv; v.data = d; v.last = l; v.ordy = ordy;
    v.exp_ir = ir; v.chk_ov = cov; v.exp_ov = ov; v.chk_data = cd;
    v.exp_sum = s; v.exp_c = c; v.exp_o = o; v.exp_cnt = n;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 0;  bus.in_data = '0;  bus.in_last = 0;  bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.in_last = 0; bus2.out_ready = 0;

    //   rst iv data          last ordy ir  cov ov  cd  sum           c  o  cnt
    add(1, 0, 32'h0,        0, 0,   0,  1,  0,  1,  32'h0,        0, 0, 0);
    // 1 + 2 + 3
    add(0, 1, 32'h1,        0, 1,   1,  1,  0,  0,  32'h0,        0, 0, 0);
    add(0, 1, 32'h2,        0, 1,   1,  1,  0,  0,  32'h0,        0, 0, 0);
    add(0, 1, 32'h3,        1, 1,   1,  1,  0,  0,  32'h0,        0, 0, 0);
    add(0, 0, 32'h0,        0, 1,   0,  1,  1,  1,  32'h6,        0, 0, 3);
    // unsigned carry out; out_ready asserted in ACCUM is ignored
    add(0, 1, 32'hFFFFFFFF, 0, 0,   1,  1,  0,  0,  32'h0,        0, 0, 0);
    add(0, 1, 32'h2,        1, 1,   1,  1,  0,  0,  32'h0,        0, 0, 0);
    add(0, 0, 32'h0,        0, 1,   0,  1,  1,  1,  32'h1,        1, 0, 2);
    // signed overflow, then hold with in_valid high for 5 cycles
    add(0, 1, 32'h7FFFFFFF, 0, 1,   1,  1,  0,  0,  32'h0,        0, 0, 0);
    add(0, 1, 32'h1,        1, 0,   1,  1,  0,  0,  32'h0,        0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'hDEADBEEF, 1, 0, 0,  1,  1,  1,  32'h80000000, 0, 1, 2);
    add(0, 1, 32'hDEADBEEF, 1, 1,   0,  1,  1,  1,  32'h80000000, 0, 1, 2);
    add(0, 0, 32'h0,        0, 0,   1,  1,  0,  1,  32'h0,        0, 0, 0);
    // reset mid-packet discards the partial sum
    add(0, 1, 32'h5,        0, 0,   1,  1,  0,  0,  32'h0,        0, 0, 0);
    add(0, 1, 32'h6,        0, 0,   1,  1,  0,  0,  32'h0,        0, 0, 0);
    add(1, 1, 32'h7,        0, 0,   0,  1,  0,  0,  32'h0,        0, 0, 0);
    add(0, 1, 32'hA,        1, 0,   1,  1,  0,  1,  32'h0,        0, 0, 0);
    add(0, 0, 32'h0,        0, 0,   0,  1,  1,  1,  32'hA,        0, 0, 1);
    add(0, 0, 32'h0,        0, 0,   0,  1,  1,  1,  32'hA,        0, 0, 1);
    // reset while holding drops the result
    add(1, 0, 32'h0,        0, 0,   0,  0,  0,  0,  32'h0,        0, 0, 0);
    add(0, 0, 32'h0,        0, 0,   1,  1,  0,  1,  32'h0,        0, 0, 0);

    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].rst;
      bus.in_valid  = vecs[i].iv;
      bus.in_data   = vecs[i].data;
      bus.in_last   = vecs[i].last;
      bus.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'b0, bus.in_ready}, {31'b0, vecs[i].exp_ir});
      if (vecs[i].chk_ov)
        chk($sformatf("v%0d out_valid", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].exp_ov});
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d out_sum", i), bus.out_sum, vecs[i].exp_sum);
        chk($sformatf("v%0d out_carry", i), {31'b0, bus.out_carry}, {31'b0, vecs[i].exp_c});
        chk($sformatf("v%0d out_overflow", i), {31'b0, bus.out_overflow},
            {31'b0, vecs[i].exp_o});
        chk($sformatf("v%0d out_count", i), {24'b0, bus.out_count}, {24'b0, vecs[i].exp_cnt});
      end
      @(negedge clk);
    end

    // Saturating count on the CNT_W = 2 instance: five beats of 1
    rst = 1'b0;
    bus.in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1;
      bus2.in_data  = 32'h1;
      bus2.in_last  = (i == 4);
      #1;
      chk($sformatf("sat beat%0d in_ready", i), {31'b0, bus2.in_ready}, 32'h1);
      @(negedge clk);
    end
    bus2.in_valid = 0;
    bus2.in_last  = 0;
    begin
      int waited;
      waited = 0;
      while (!bus2.out_valid && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      chk("sat out_valid latency", waited, 0);
    end
    chk("sat out_count", {30'b0, bus2.out_count}, 32'h3);
    chk("sat out_sum", bus2.out_sum, 32'h5);
    bus2.out_ready = 1;
    @(negedge clk);
    bus2.out_ready = 0;
    chk("sat released", {31'b0, bus2.out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
